// File: rtl/tt_byte_regbridge_if.sv
// Pin bundle between a TinyTapeout-style top and the byte register bridge.
// The host side drives ena/ui_in/uio_in; the bridge drives uo_out/uio_out/uio_oe.
interface tt_byte_regbridge_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_byte_regbridge.sv
// Byte-serial register bridge: a host toggles uio_in[0] to clock command and data
// bytes in on ui_in, writing or reading NREG registers of REGW bits.
module tt_byte_regbridge #(
    parameter int NREG = 4,
    parameter int REGW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tt_byte_regbridge_if.slave     pins,
    output logic [NREG*REGW-1:0]   reg_o,
    output logic [NREG-1:0]        wr_pulse_o
);
    localparam int NB = REGW / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [7:0]      r_ui_s1, r_ui_s2;
    logic [1:0]      r_uio_s1, r_uio_s2;
    logic            r_stb_s3;
    logic [6:0]      r_addr, w_addr_next;
    logic [3:0]      r_idx, w_idx_next;
    logic            r_err, w_err_next;
    logic [REGW-1:0] r_stage, w_stage_next;
    logic [REGW-1:0] r_shift, w_shift_next;
    logic [REGW-1:0] w_rd_data;
    logic            w_commit;
    logic            w_frst, w_event;
    logic            w_cmd_ok, w_addr_ok;
    logic            w_unused;

    assign w_unused = ^pins.uio_in[7:2];

    // Strobe edge tracker runs regardless of ena so a dropped toggle never replays later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ui_s1  <= '0;
            r_ui_s2  <= '0;
            r_uio_s1 <= '0;
            r_uio_s2 <= '0;
            r_stb_s3 <= 1'b0;
        end else begin
            r_ui_s1  <= pins.ui_in;
            r_ui_s2  <= r_ui_s1;
            r_uio_s1 <= pins.uio_in[1:0];
            r_uio_s2 <= r_uio_s1;
            r_stb_s3 <= r_uio_s2[0];
        end
    end

    assign w_frst    = r_uio_s2[1];
    assign w_event   = pins.ena && (r_uio_s2[0] != r_stb_s3) && !w_frst;
    assign w_cmd_ok  = int'(r_ui_s2[6:0]) < NREG;
    assign w_addr_ok = int'(r_addr) < NREG;

    // Snapshot source for a read command, addressed by the incoming command byte.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(r_ui_s2[6:0]) == k) begin
                w_rd_data = reg_o[k*REGW +: REGW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_stage <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_idx   <= w_idx_next;
            r_err   <= w_err_next;
            r_stage <= w_stage_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_idx_next   = r_idx;
        w_err_next   = r_err;
        w_stage_next = r_stage;
        w_shift_next = r_shift;
        w_commit     = 1'b0;
        if (w_frst) begin
            w_state_next = ST_IDLE;
            w_idx_next   = '0;
            w_err_next   = 1'b0;
            w_stage_next = '0;
            w_shift_next = '0;
        end else if (w_event) begin
            case (r_state)
                ST_IDLE: begin
                    w_addr_next = r_ui_s2[6:0];
                    w_idx_next  = '0;
                    if (!w_cmd_ok) begin
                        w_err_next = 1'b1;
                    end
                    if (r_ui_s2[7]) begin
                        w_state_next = ST_RDATA;
                        w_shift_next = w_cmd_ok ? w_rd_data : '0;
                    end else begin
                        w_state_next = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    w_stage_next[r_idx*8 +: 8] = r_ui_s2;
                    if (int'(r_idx) == NB - 1) begin
                        w_commit     = w_addr_ok;
                        w_state_next = ST_IDLE;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + 4'd1;
                    end
                end
                ST_RDATA: begin
                    if (int'(r_idx) == NB - 1) begin
                        w_state_next = ST_IDLE;
                        w_idx_next   = '0;
                        w_shift_next = '0;
                    end else begin
                        w_idx_next   = r_idx + 4'd1;
                        w_shift_next = r_shift >> 8;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    // Each register commits the full staged frame (including the final byte) in one edge.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic [REGW-1:0] r_val;
        logic            r_pulse;
        logic            w_hit;

        assign w_hit = w_commit && (int'(r_addr) == gi);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_val   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_hit;
                if (w_hit) begin
                    r_val <= w_stage_next;
                end
            end
        end

        assign reg_o[gi*REGW +: REGW] = r_val;
        assign wr_pulse_o[gi]         = r_pulse;
    end

    assign pins.uo_out  = r_shift[7:0];
    assign pins.uio_out = {r_idx, r_err, (r_state != ST_IDLE), 2'b00};
    assign pins.uio_oe  = 8'hFC;
endmodule

// File: tb/tb_tt_byte_regbridge.sv
// Directed bench for tt_byte_regbridge (NREG=4, REGW=16) with queue-based
// scoreboards for write pulses and read-back bytes.
module tb_tt_byte_regbridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] reg_o;
    logic [3:0]  wr_pulse_o;
    logic        stb = 1'b0;
    logic [15:0] model [4];
    logic [17:0] q_wr [$];
    logic [7:0]  q_rd [$];
    int          n_checks = 0;
    int          n_errors = 0;

    tt_byte_regbridge_if bus ();

    tt_byte_regbridge #(.NREG(4), .REGW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pins       (bus),
        .reg_o      (reg_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_vec();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Commit monitor: every pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_pulse_o !== 4'b0000) begin
            if (q_wr.size() == 0) begin
                check("pulse_unexpected", {60'd0, wr_pulse_o}, 64'd0);
            end else begin
                logic [17:0] e;
                e = q_wr.pop_front();
                check("pulse_mask", {60'd0, wr_pulse_o}, 64'(4'b0001 << e[17:16]));
                check("pulse_data", {48'd0, reg_o[e[17:16]*16 +: 16]}, {48'd0, e[15:0]});
            end
        end
    end

    task automatic strobe(input logic [7:0] b);
        bus.ui_in = b;
        repeat (4) @(negedge clk);
        stb = ~stb;
        bus.uio_in[0] = stb;
        repeat (5) @(negedge clk);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [15:0] d);
        if (a < 7'd4) q_wr.push_back({a[1:0], d});
        strobe({1'b0, a});
        strobe(d[7:0]);
        strobe(d[15:8]);
        if (a < 7'd4) model[a[1:0]] = d;
        check("wr_reg_o", reg_o, model_vec());
        check("wr_pulse_drained", 64'(q_wr.size()), 64'd0);
    endtask

    task automatic read_reg(input logic [6:0] a, input logic err_exp);
        logic [15:0] v;
        logic [7:0]  exp_b;
        v = (a < 7'd4) ? model[a[1:0]] : 16'h0000;
        q_rd.push_back(v[7:0]);
        q_rd.push_back(v[15:8]);
        strobe({1'b1, a});
        for (int i = 0; i < 2; i++) begin
            exp_b = q_rd.pop_front();
            check($sformatf("rd_byte%0d_a%0d", i, a), {56'd0, bus.uo_out}, {56'd0, exp_b});
            check("rd_status", {56'd0, bus.uio_out}, {56'd0, 4'(i), err_exp, 3'b100});
            strobe(8'h00);
        end
        check("rd_end_uo", {56'd0, bus.uo_out}, 64'd0);
        check("rd_end_status", {56'd0, bus.uio_out}, {56'd0, 4'd0, err_exp, 3'b000});
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_uo", {56'd0, bus.uo_out}, 64'd0);
        check("rst_uio_out", {56'd0, bus.uio_out}, 64'd0);
        check("rst_uio_oe", {56'd0, bus.uio_oe}, 64'hFC);
        check("rst_reg_o", reg_o, 64'd0);
        check("rst_pulse", {60'd0, wr_pulse_o}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: write 0x1234 to reg 2, with status checks mid-frame
        q_wr.push_back({2'd2, 16'h1234});
        strobe(8'h02);
        check("w_status_cmd", {56'd0, bus.uio_out}, 64'h04);
        strobe(8'h34);
        check("w_status_b0", {56'd0, bus.uio_out}, 64'h14);
        check("w_partial_reg_o", reg_o, 64'd0);
        strobe(8'h12);
        model[2] = 16'h1234;
        check("w1_reg_o", reg_o, 64'h0000_1234_0000_0000);
        check("w1_status", {56'd0, bus.uio_out}, 64'h00);

        // 2: read reg 2 back
        read_reg(7'd2, 1'b0);

        // 3: bad address write and read
        write_reg(7'd5, 16'hBBAA);
        check("bad_err", {56'd0, bus.uio_out}, 64'h08);
        read_reg(7'd5, 1'b1);

        // 4: frame reset mid-write, strobe ignored while held, then a full write
        strobe(8'h01);
        strobe(8'h55);
        bus.uio_in[1] = 1'b1;
        repeat (5) @(negedge clk);
        strobe(8'h81);
        check("frst_hold_status", {56'd0, bus.uio_out}, 64'h00);
        bus.uio_in[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("frst_status", {56'd0, bus.uio_out}, 64'h00);
        check("frst_uo", {56'd0, bus.uo_out}, 64'd0);
        check("frst_reg_o", reg_o, model_vec());
        write_reg(7'd1, 16'h7766);

        // 5: ena low drops strobes; async reset mid-read
        bus.ena = 1'b0;
        strobe(8'h03);
        strobe(8'h11);
        strobe(8'h22);
        check("ena_status", {56'd0, bus.uio_out}, 64'h00);
        check("ena_reg_o", reg_o, model_vec());
        bus.ena = 1'b1;
        strobe(8'h82);
        check("pre_rst_uo", {56'd0, bus.uo_out}, 64'h34);
        #2 rst_n = 1'b0;
        #1;
        check("async_uo", {56'd0, bus.uo_out}, 64'd0);
        check("async_uio_out", {56'd0, bus.uio_out}, 64'd0);
        check("async_reg_o", reg_o, 64'd0);
        stb = 1'b0;
        bus.uio_in = 8'h00;
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_status", {56'd0, bus.uio_out}, 64'd0);

        // 6: back-to-back random writes then read everything back
        for (int i = 0; i < 4; i++) write_reg(7'(i), 16'($urandom));
        for (int i = 0; i < 4; i++) read_reg(7'(i), 1'b0);

        check("final_pulse_queue", 64'(q_wr.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
